// File: rtl/nios2_debug_jtag_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG scan master:
// scan FSM state encoding, default IR/DR widths and the debug-slave IR map.
package nios2_debug_jtag_pkg;

  localparam int IR_WIDTH_DEF = 2;
  localparam int DR_WIDTH_DEF = 38;

  // Virtual IR encodings understood by the debug slave
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACECTRL = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACEMEM  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UIR   = 3'd1,
    ST_CDR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_UDR   = 3'd4,
    ST_RESP  = 3'd5
  } scan_state_e;

endpackage

// File: rtl/nios2_debug_jtag_scan_master_if.sv
// Command/response bundle between a host and the JTAG scan master.
// master modport: the host issuing scans; slave modport: the scan master.
interface nios2_debug_jtag_scan_master_if
  import nios2_debug_jtag_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int DR_WIDTH = DR_WIDTH_DEF
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

endinterface

// File: rtl/nios2_jtag_tck_gen.sv
// TCK generator: while enabled, produces periods of TCK_HALF cycles low followed
// by TCK_HALF cycles high, always starting low. tck_rise marks the first
// high cycle; tck_fall marks the last cycle of a period (tck drops on the
// following edge, which is where phase boundaries and tdi updates happen).
module nios2_jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = $clog2(2 * TCK_HALF);
  localparam logic [CW-1:0] HALF_C = CW'(TCK_HALF);
  localparam logic [CW-1:0] LAST_C = CW'(2 * TCK_HALF - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next position inside the TCK period; parked at zero while disabled
  always_comb begin
    cnt_s = cnt_r;
    if (en) begin
      if (cnt_r == LAST_C) begin
        cnt_s = '0;
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = '0;
    end
  end

  // Period counter and registered TCK level
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      tck   <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      tck   <= en && (cnt_s >= HALF_C);
    end
  end

  assign tck_rise = en && (cnt_r == HALF_C);
  assign tck_fall = en && (cnt_r == LAST_C);

endmodule

// File: rtl/nios2_debug_jtag_scan_master.sv
// Host-side virtual-JTAG scan master for the Nios II debug slave.
// One command = optional IR update (UIR), capture (CDR), DR_WIDTH-bit LSB-first
// shift (SDR) and update (UDR); the captured TDO word is returned as a response.
// Optional feature macro: NIOS2_JTAG_SCAN_IR_CACHE_EN skips UIR when the
// requested IR equals the one last loaded since reset.
module nios2_debug_jtag_scan_master
  import nios2_debug_jtag_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_HALF = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  nios2_debug_jtag_scan_master_if.slave host,
  output logic                      tck,
  output logic                      tdi,
  input  logic                      tdo,
  output logic [IR_WIDTH-1:0]       ir_in,
  input  logic [IR_WIDTH-1:0]       ir_out,
  output logic                      vs_uir,
  output logic                      vs_cdr,
  output logic                      vs_sdr,
  output logic                      vs_udr,
  output logic                      jtag_state_rti
);

  localparam int BW = $clog2(DR_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

  scan_state_e         state_r;
  scan_state_e         state_s;
  logic [BW-1:0]       bit_cnt_r;
  logic [DR_WIDTH-1:0] dr_sh_r;
  logic [DR_WIDTH-1:0] cap_r;
  logic [IR_WIDTH-1:0] ir_cap_r;
  logic [IR_WIDTH-1:0] ir_in_r;
  logic                tdi_r;
  logic                cmd_ready_r;
  logic                rsp_valid_r;
  logic [DR_WIDTH-1:0] rsp_dr_r;
  logic [IR_WIDTH-1:0] rsp_ir_out_r;
  logic                vs_uir_r, vs_cdr_r, vs_sdr_r, vs_udr_r, rti_r;
  logic                tck_en_s, tck_rise_s, tck_fall_s;
  logic                accept_s;
  logic                ir_hit_s;

  assign accept_s = host.cmd_valid && cmd_ready_r;
  assign tck_en_s = (state_r != ST_IDLE) && (state_r != ST_RESP);

  nios2_jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en_s),
    .tck      (tck),
    .tck_rise (tck_rise_s),
    .tck_fall (tck_fall_s)
  );

`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
  logic ir_cached_r;

  assign ir_hit_s = ir_cached_r && (host.cmd_ir == ir_in_r);

  // Remember that ir_in holds a loaded IR; cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_cached_r <= 1'b0;
    end else if (accept_s && !ir_hit_s) begin
      ir_cached_r <= 1'b1;
    end else begin
      ir_cached_r <= ir_cached_r;
    end
  end
`else
  assign ir_hit_s = 1'b0;
`endif

  // Next-state logic; phases advance on the last cycle of a TCK period
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ir_hit_s ? ST_CDR : ST_UIR;
        else          state_s = ST_IDLE;
      end
      ST_UIR: begin
        if (tck_fall_s) state_s = ST_CDR;
        else            state_s = ST_UIR;
      end
      ST_CDR: begin
        if (tck_fall_s) state_s = ST_SHIFT;
        else            state_s = ST_CDR;
      end
      ST_SHIFT: begin
        if (tck_fall_s && (bit_cnt_r == LAST_BIT)) state_s = ST_UDR;
        else                                       state_s = ST_SHIFT;
      end
      ST_UDR: begin
        if (tck_fall_s) state_s = ST_RESP;
        else            state_s = ST_UDR;
      end
      ST_RESP: begin
        if (rsp_valid_r && host.rsp_ready) state_s = ST_IDLE;
        else                               state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and strobes registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rti_r       <= 1'b1;
      rsp_valid_r <= 1'b0;
      vs_uir_r    <= 1'b0;
      vs_cdr_r    <= 1'b0;
      vs_sdr_r    <= 1'b0;
      vs_udr_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      rti_r       <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      vs_uir_r    <= (state_s == ST_UIR);
      vs_cdr_r    <= (state_s == ST_CDR);
      vs_sdr_r    <= (state_s == ST_SHIFT);
      vs_udr_r    <= (state_s == ST_UDR);
    end
  end

  // IR register presented to the slave; loaded only when UIR is entered
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_in_r <= '0;
    end else if (accept_s && !ir_hit_s) begin
      ir_in_r <= host.cmd_ir;
    end else begin
      ir_in_r <= ir_in_r;
    end
  end

  // Outgoing DR shifter, bit counter and tdi; tdi moves only when TCK drops
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_sh_r   <= '0;
      bit_cnt_r <= '0;
      tdi_r     <= 1'b0;
    end else if (accept_s) begin
      dr_sh_r   <= host.cmd_dr;
      bit_cnt_r <= '0;
      tdi_r     <= tdi_r;
    end else if ((state_r == ST_CDR) && tck_fall_s) begin
      dr_sh_r   <= dr_sh_r;
      bit_cnt_r <= '0;
      tdi_r     <= dr_sh_r[0];
    end else if ((state_r == ST_SHIFT) && tck_fall_s) begin
      dr_sh_r   <= {1'b0, dr_sh_r[DR_WIDTH-1:1]};
      bit_cnt_r <= bit_cnt_r + BW'(1);
      tdi_r     <= (bit_cnt_r == LAST_BIT) ? 1'b0 : dr_sh_r[1];
    end else begin
      dr_sh_r   <= dr_sh_r;
      bit_cnt_r <= bit_cnt_r;
      tdi_r     <= tdi_r;
    end
  end

  // TDO capture on TCK rise: enters at the MSB and shifts right
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_r    <= '0;
      ir_cap_r <= '0;
    end else if ((state_r == ST_SHIFT) && tck_rise_s) begin
      cap_r    <= {tdo, cap_r[DR_WIDTH-1:1]};
      ir_cap_r <= ir_cap_r;
    end else if ((state_r == ST_CDR) && tck_rise_s) begin
      cap_r    <= cap_r;
      ir_cap_r <= ir_out;
    end else begin
      cap_r    <= cap_r;
      ir_cap_r <= ir_cap_r;
    end
  end

  // Response payload published on entry to RESP and held until the next scan
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_dr_r     <= '0;
      rsp_ir_out_r <= '0;
    end else if ((state_r == ST_UDR) && tck_fall_s) begin
      rsp_dr_r     <= cap_r;
      rsp_ir_out_r <= ir_cap_r;
    end else begin
      rsp_dr_r     <= rsp_dr_r;
      rsp_ir_out_r <= rsp_ir_out_r;
    end
  end

  assign host.cmd_ready  = cmd_ready_r;
  assign host.rsp_valid  = rsp_valid_r;
  assign host.rsp_dr     = rsp_dr_r;
  assign host.rsp_ir_out = rsp_ir_out_r;
  assign tdi             = tdi_r;
  assign ir_in           = ir_in_r;
  assign vs_uir          = vs_uir_r;
  assign vs_cdr          = vs_cdr_r;
  assign vs_sdr          = vs_sdr_r;
  assign vs_udr          = vs_udr_r;
  assign jtag_state_rti  = rti_r;

endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// Directed bench for nios2_debug_jtag_scan_master: loopback / tied-high TDO,
// response backpressure, reset during SHIFT, IR cache (when
// NIOS2_JTAG_SCAN_IR_CACHE_EN is defined) and a TCK_HALF=1 instance.
module tb_nios2_debug_jtag_scan_master;
  import nios2_debug_jtag_pkg::*;

  localparam int DRW = 38;
  localparam int IRW = 2;

`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
  localparam int LAT_HIT = 161;
  localparam int UIR_HIT = 0;
`else
  localparam int LAT_HIT = 165;
  localparam int UIR_HIT = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  nios2_debug_jtag_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) h0 ();
  nios2_debug_jtag_scan_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) h1 ();

  logic           tck0, tdi0, tdo0, vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0;
  logic [IRW-1:0] ir_in0, ir_out0;
  logic           tck1, tdi1, tdo1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;
  logic [IRW-1:0] ir_in1, ir_out1;
  logic           tdo_one;

  // Slave models: TDO looped back (or tied high); ir_out shows a distinct value in CDR
  assign tdo0    = tdo_one ? 1'b1 : tdi0;
  assign tdo1    = tdi1;
  assign ir_out0 = vs_cdr0 ? IR_TRACECTRL : IR_TRACEMEM;
  assign ir_out1 = vs_cdr1 ? IR_BREAK : IR_TRACECTRL;

  nios2_debug_jtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(2)) dut (
    .clk(clk), .reset(reset), .host(h0), .tck(tck0), .tdi(tdi0), .tdo(tdo0),
    .ir_in(ir_in0), .ir_out(ir_out0), .vs_uir(vs_uir0), .vs_cdr(vs_cdr0),
    .vs_sdr(vs_sdr0), .vs_udr(vs_udr0), .jtag_state_rti(rti0)
  );

  nios2_debug_jtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) dut1 (
    .clk(clk), .reset(reset), .host(h1), .tck(tck1), .tdi(tdi1), .tdo(tdo1),
    .ir_in(ir_in1), .ir_out(ir_out1), .vs_uir(vs_uir1), .vs_cdr(vs_cdr1),
    .vs_sdr(vs_sdr1), .vs_udr(vs_udr1), .jtag_state_rti(rti1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command to dut; returns on the first cycle rsp_valid is seen
  task automatic scan0(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                       output int lat, output int uir_n, output int sdr_n, output int tdi_n);
    lat = 0; uir_n = 0; sdr_n = 0; tdi_n = 0;
    h0.cmd_ir = ir;
    h0.cmd_dr = dr;
    h0.cmd_valid = 1'b1;
    check("cmd_ready_at_accept", 64'(h0.cmd_ready), 64'd1);
    tick();
    h0.cmd_valid = 1'b0;
    lat = 1;
    while (h0.rsp_valid !== 1'b1 && lat < 400) begin
      if (vs_uir0) uir_n++;
      if (vs_sdr0) begin
        sdr_n++;
        if (tdi0) tdi_n++;
      end
      tick();
      lat++;
    end
  endtask

  int lat, uir_n, sdr_n, tdi_n, bad, cnt;
  logic [DRW-1:0] saved;

  initial begin
    reset = 1'b1;
    tdo_one = 1'b0;
    h0.cmd_valid = 1'b0; h0.cmd_ir = '0; h0.cmd_dr = '0; h0.rsp_ready = 1'b1;
    h1.cmd_valid = 1'b0; h1.cmd_ir = '0; h1.cmd_dr = '0; h1.rsp_ready = 1'b1;
    tick();
    tick();
    check("reset_values",
          64'({tck0, tdi0, ir_in0, vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0,
               h0.cmd_ready, h0.rsp_valid, h0.rsp_dr, h0.rsp_ir_out}),
          64'({1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 38'd0, 2'b00}));
    reset = 1'b0;
    tick();

    // Loopback scan with IR=BREAK
    scan0(IR_BREAK, 38'h2A_5555_AAAA, lat, uir_n, sdr_n, tdi_n);
    check("loop_latency", 64'(lat), 64'd165);
    check("loop_rsp_dr", 64'(h0.rsp_dr), 64'h2A_5555_AAAA);
    check("loop_ir_in", 64'(ir_in0), 64'(IR_BREAK));
    check("loop_rsp_ir_out", 64'(h0.rsp_ir_out), 64'(IR_TRACECTRL));
    check("loop_uir_cycles", 64'(uir_n), 64'd4);
    check("loop_sdr_cycles", 64'(sdr_n), 64'd152);
    tick();
    check("rsp_valid_one_cycle", 64'({h0.rsp_valid, h0.cmd_ready}), 64'({1'b0, 1'b1}));

    // TDO tied high, zero payload
    tdo_one = 1'b1;
    scan0(IR_TRACEMEM, 38'd0, lat, uir_n, sdr_n, tdi_n);
    check("ones_latency", 64'(lat), 64'd165);
    check("ones_rsp_dr", 64'(h0.rsp_dr), 64'h3F_FFFF_FFFF);
    check("ones_tdi_in_shift", 64'(tdi_n), 64'd0);
    check("ones_ir_in", 64'(ir_in0), 64'(IR_TRACEMEM));
    tick();
    tdo_one = 1'b0;

    // Response backpressure for 20 cycles with ignored cmd_valid pulses
    h0.rsp_ready = 1'b0;
    scan0(IR_OCIMEM, 38'h15_0F0F_3C3C, lat, uir_n, sdr_n, tdi_n);
    check("hold_rsp_dr", 64'(h0.rsp_dr), 64'h15_0F0F_3C3C);
    saved = h0.rsp_dr;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      h0.cmd_valid = (i % 2 == 1);
      h0.cmd_ir = IR_BREAK;
      tick();
      if (h0.rsp_dr !== saved || h0.cmd_ready !== 1'b0 || h0.rsp_valid !== 1'b1) bad++;
    end
    h0.cmd_valid = 1'b0;
    check("hold_stable_cycles_bad", 64'(bad), 64'd0);
    h0.rsp_ready = 1'b1;
    tick();
    check("hold_released", 64'({h0.rsp_valid, h0.cmd_ready}), 64'({1'b0, 1'b1}));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vs_uir0 !== 1'b0 || rti0 !== 1'b1) bad++;
    end
    check("hold_no_queued_cmd", 64'(bad), 64'd0);

    // Reset during SHIFT bit 10
    h0.cmd_ir = IR_TRACECTRL;
    h0.cmd_dr = 38'h3F_0000_FFFF;
    h0.cmd_valid = 1'b1;
    tick();
    h0.cmd_valid = 1'b0;
    repeat (49) tick();
    check("abort_in_shift", 64'({vs_sdr0, tdi0}), 64'({1'b1, 1'b1}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_reset_values",
          64'({tck0, tdi0, ir_in0, vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0,
               h0.cmd_ready, h0.rsp_valid, h0.rsp_dr, h0.rsp_ir_out}),
          64'({1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 38'd0, 2'b00}));
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (h0.rsp_valid) cnt++;
    end
    check("abort_no_response", 64'(cnt), 64'd0);
    scan0(IR_BREAK, 38'h01_2345_6789, lat, uir_n, sdr_n, tdi_n);
    check("after_abort_latency", 64'(lat), 64'd165);
    check("after_abort_rsp_dr", 64'(h0.rsp_dr), 64'h01_2345_6789);
    check("after_abort_uir", 64'(uir_n), 64'd4);
    tick();

    // Repeated IR after reset (IR cache behaviour)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    scan0(IR_TRACECTRL, 38'h12_3456_789A, lat, uir_n, sdr_n, tdi_n);
    check("cache_first_latency", 64'(lat), 64'd165);
    check("cache_first_uir", 64'(uir_n), 64'd4);
    check("cache_first_rsp_dr", 64'(h0.rsp_dr), 64'h12_3456_789A);
    tick();
    scan0(IR_TRACECTRL, 38'h0F_EDCB_A987, lat, uir_n, sdr_n, tdi_n);
    check("cache_second_latency", 64'(lat), 64'(LAT_HIT));
    check("cache_second_uir", 64'(uir_n), 64'(UIR_HIT));
    check("cache_second_rsp_dr", 64'(h0.rsp_dr), 64'h0F_EDCB_A987);
    check("cache_second_ir_in", 64'(ir_in0), 64'(IR_TRACECTRL));
    tick();

    // TCK_HALF=1 instance
    h1.cmd_ir = IR_OCIMEM;
    h1.cmd_dr = 38'h2A_5555_AAAA;
    h1.cmd_valid = 1'b1;
    check("half1_cmd_ready", 64'(h1.cmd_ready), 64'd1);
    tick();
    h1.cmd_valid = 1'b0;
    lat = 1;
    while (h1.rsp_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    check("half1_latency", 64'(lat), 64'd83);
    check("half1_rsp_ir_out", 64'(h1.rsp_ir_out), 64'(2'b10));
    check("half1_rsp_dr", 64'(h1.rsp_dr), 64'h2A_5555_AAAA);
    tick();
    check("half1_rsp_done", 64'({h1.rsp_valid, h1.cmd_ready}), 64'({1'b0, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_debug_jtag_scan_master.md
# nios2_debug_jtag_scan_master

Synchronous host-side driver for the Nios II debug slave's virtual-JTAG port. It accepts one scan command per transaction (2-bit IR plus 38-bit DR payload) and generates the TCK/TDI stream and the UIR/CDR/SDR/UDR virtual-state strobes. It captures TDO and returns the shifted-out DR word. It sits in the system-clock domain and replaces the hub when the debug slave is driven on-chip or in simulation.

## Interface
- `DR_WIDTH`, default 38: DR shift length in bits; matches the slave's `jdo`/`sr` width.
- `IR_WIDTH`, default 2: virtual IR width.
- `TCK_HALF`, default 2: `clk` cycles per TCK half-period; must be ≥1. P = 2*`TCK_HALF`.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  the block accepts a command this cycle.
- `cmd_ir`  in  IR_WIDTH  virtual IR value to load.
- `cmd_dr`  in  DR_WIDTH  DR value to shift in, LSB first.
- `rsp_valid`  out  1  a response is held.
- `rsp_ready`  in  1  the consumer takes the response.
- `rsp_dr`  out  DR_WIDTH  DR value captured from `tdo`.
- `rsp_ir_out`  out  IR_WIDTH  `ir_out`, sampled during the CDR phase.
- `tck`  out  1  generated TCK.
- `tdi`  out  1  serial data to the slave.
- `tdo`  in  1  serial data from the slave.
- `ir_in`  out  IR_WIDTH  virtual IR presented to the slave.
- `ir_out`  in  IR_WIDTH  slave status.
- `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_udr`  out  1 each  virtual-state strobes.
- `jtag_state_rti`  out  1  high in IDLE only.

## Operation
- States and transitions:
  - IDLE → UIR on accept.
  - UIR → CDR.
  - CDR → SHIFT.
  - SHIFT → UDR after `DR_WIDTH` TCK periods.
  - UDR → RESP.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Accept rule: `cmd_ready` = (state == IDLE) && !`rsp_valid`. A command is accepted on `cmd_valid && cmd_ready`. `cmd_ir` and `cmd_dr` are latched on the accept cycle.
- `ir_in` is updated to the latched IR on entry to UIR and held until the next UIR.
- UIR, CDR and UDR each last exactly one TCK period (P cycles). The matching strobe is high for the whole period.
- SHIFT holds `vs_sdr` high for `DR_WIDTH`*P cycles.
- Shift order is LSB first:
  - `tdi` = latched DR bit i during TCK period i.
  - `tdo` is sampled on the `clk` cycle where `tck` rises. It is shifted into the capture register MSB, and the register shifts right.
  - After `DR_WIDTH` bits, `rsp_dr`[i] = `tdo` sample of period i.
- `rsp_ir_out` is sampled from `ir_out` on the TCK rising edge inside CDR.
- `rsp_valid` is asserted on entry to RESP. It holds `rsp_dr` and `rsp_ir_out` stable until the handshake.
- Reset values: `tck`=0, `tdi`=0, `ir_in`=0, all `vs_*`=0, `jtag_state_rti`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_dr`=0, `rsp_ir_out`=0.
- Reset mid-scan aborts at once: state returns to IDLE, no response is produced, and `tck` returns low on the next edge.
- `cmd_valid` is ignored while `cmd_ready`=0; the command is not queued.

## Timing
- TCK is low for `TCK_HALF` cycles, then high for `TCK_HALF` cycles. Each phase begins with TCK low.
- `tdi` and the strobes change only on the cycle TCK goes low, which gives the slave a half-period of setup.
- Latency from the accept cycle to the first `rsp_valid` cycle: (`DR_WIDTH`+3)*P+1 cycles. With defaults this is 165.
- Back-to-back throughput: the next accept comes at the earliest on the cycle after the RSP handshake.
- `rsp_ready` held high: `rsp_valid` is high for exactly one cycle.

## Configuration
- `NIOS2_JTAG_SCAN_IR_CACHE_EN` defined:
  - UIR is skipped when the latched `cmd_ir` equals the IR last loaded since reset.
  - Latency becomes (`DR_WIDTH`+2)*P+1.
  - Reset invalidates the cache, so the first scan after reset always performs UIR.
- Not defined: every scan performs UIR.

## Structure
- Shared package `nios2_debug_jtag_pkg` holds:
  - the state enum;
  - `IR_WIDTH` and `DR_WIDTH` default constants;
  - IR encodings: 0 = OCIMEM, 1 = TRACECTRL, 2 = BREAK, 3 = TRACEMEM.
- Sub-module `nios2_jtag_tck_gen`: half-period counter producing `tck`, a `tck_rise` pulse and a `tck_fall` pulse. It is enabled outside IDLE and RESP.

## Test plan
- Reset, then `cmd_ir`=2, `cmd_dr`=38'h2A_5555_AAAA, slave TDO looped to TDI:
  - `rsp_dr`=38'h2A_5555_AAAA;
  - `rsp_valid` on cycle 165 after accept;
  - `ir_in`=2.
- TDO tied to 1, `cmd_dr`=0 → `rsp_dr`=38'h3F_FFFF_FFFF; `tdi` is 0 throughout SHIFT.
- Hold `rsp_ready`=0 for 20 cycles after `rsp_valid`:
  - `rsp_dr` is stable and `cmd_ready`=0 throughout;
  - `cmd_valid` pulses during the hold are ignored.
- Assert `reset` in SHIFT bit 10:
  - next cycle all outputs are at their reset values;
  - no `rsp_valid`;
  - a following scan completes normally.
- With `NIOS2_JTAG_SCAN_IR_CACHE_EN`, two scans with `cmd_ir`=1:
  - the first has UIR and latency 165;
  - the second has no `vs_uir` pulse and latency 161.
- `TCK_HALF`=1, `ir_out`=2'b10 during CDR → `rsp_ir_out`=2'b10; latency (38+3)*2+1=83.
